// File: rtl/cal_pkg.sv
// Shared definitions for the UART calculator: operator encoding,
// parser error codes, ASCII byte constants and the default operand width.
package cal_pkg;

    localparam int OPW_DEF = 16;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } cal_op_e;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_SPACE = 3'd1;
    localparam logic [2:0] ERR_FMT   = 3'd2;
    localparam logic [2:0] ERR_DIGIT = 3'd3;
    localparam logic [2:0] ERR_OP    = 3'd4;
    localparam logic [2:0] ERR_EQ    = 3'd5;
    localparam logic [2:0] ERR_OVR   = 3'd6;

    localparam logic [7:0] ASC_I     = 8'h49;
    localparam logic [7:0] ASC_S     = 8'h53;
    localparam logic [7:0] ASC_U     = 8'h55;
    localparam logic [7:0] ASC_SP    = 8'h20;
    localparam logic [7:0] ASC_PLUS  = 8'h2B;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_STAR  = 8'h2A;
    localparam logic [7:0] ASC_SLASH = 8'h2F;
    localparam logic [7:0] ASC_EQ    = 8'h3D;
    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_9     = 8'h39;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASC_0) && (b <= ASC_9);
    endfunction

endpackage

// File: rtl/cal_dec_acc.sv
// Decimal accumulator shared by both operands of the command parser.
// Ports: clr (zero acc), step (acc = acc*10 + digit), digit, neg; res = finished value.
module cal_dec_acc #(
    parameter int OPW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           step,
    input  logic [3:0]     digit,
    input  logic           neg,
    output logic [OPW-1:0] res
);

    logic [OPW-1:0] acc;
    logic [OPW-1:0] nxt;

    // x10 as shift-and-add, kept to OPW bits
    assign nxt = (acc << 3) + (acc << 1) + {{(OPW-4){1'b0}}, digit};
    // res is the value including the digit on the current byte, so the
    // parser can latch it on the same edge as the last digit arrives
    assign res = neg ? (~nxt + {{(OPW-1){1'b0}}, 1'b1}) : nxt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (step) begin
            acc <= nxt;
        end
    end

endmodule

// File: rtl/cal_cmd_parser.sv
// Byte-level parser for "I <S|U> <A><op><B>=" frames from the UART receiver.
// Ports: rx_valid/rx_data in; cmd_* valid/ready out; err/err_code pulse; busy.
module cal_cmd_parser
    import cal_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int OPW    = OPW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx_valid,
    input  logic [7:0]     rx_data,
    output logic           cmd_valid,
    input  logic           cmd_ready,
    output logic           cmd_signed,
    output logic [1:0]     cmd_op,
    output logic [OPW-1:0] cmd_a,
    output logic [OPW-1:0] cmd_b,
    output logic           err,
    output logic [2:0]     err_code,
    output logic           busy
);

    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SP1,
        S_FMT,
        S_SP2,
        S_A_DIG,
        S_OP,
        S_B_DIG,
        S_EQ,
        S_HOLD
    } state_e;

    state_e         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           neg, neg_n;
    logic           ld_fmt, fmt_d;
    logic           ld_op;
    cal_op_e        op_d;
    logic           ld_a, ld_b;
    logic           err_d;
    logic [2:0]     code_d;
    logic           acc_clr, acc_step;
    logic           fault;
    logic [2:0]     fault_code;
    logic           dig, last;
    logic [OPW-1:0] acc_res;

    assign dig  = is_digit(rx_data);
    assign last = (cnt == CW'(DIGITS - 1));

    cal_dec_acc #(
        .OPW (OPW)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .clr   (acc_clr),
        .step  (acc_step),
        .digit (rx_data[3:0]),
        .neg   (neg),
        .res   (acc_res)
    );

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        neg_n      = neg;
        ld_fmt     = 1'b0;
        fmt_d      = (rx_data == ASC_S);
        ld_op      = 1'b0;
        op_d       = OP_ADD;
        ld_a       = 1'b0;
        ld_b       = 1'b0;
        err_d      = 1'b0;
        code_d     = err_code;
        acc_clr    = 1'b0;
        acc_step   = 1'b0;
        fault      = 1'b0;
        fault_code = ERR_NONE;

        if (rx_valid) begin
            case (state)
                S_IDLE: begin
                    if (rx_data == ASC_I) state_n = S_SP1;
                end
                S_SP1: begin
                    if (rx_data == ASC_SP) state_n = S_FMT;
                    else begin
                        fault      = 1'b1;
                        fault_code = ERR_SPACE;
                    end
                end
                S_FMT: begin
                    if (rx_data == ASC_S || rx_data == ASC_U) begin
                        ld_fmt  = 1'b1;
                        state_n = S_SP2;
                    end else begin
                        fault      = 1'b1;
                        fault_code = ERR_FMT;
                    end
                end
                S_SP2: begin
                    if (rx_data == ASC_SP) state_n = S_A_DIG;
                    else begin
                        fault      = 1'b1;
                        fault_code = ERR_SPACE;
                    end
                end
                S_A_DIG, S_B_DIG: begin
                    if (dig) begin
                        if (last) begin
                            // latch finished value and free the accumulator
                            ld_a    = (state == S_A_DIG);
                            ld_b    = (state == S_B_DIG);
                            acc_clr = 1'b1;
                            cnt_n   = '0;
                            neg_n   = 1'b0;
                            state_n = (state == S_A_DIG) ? S_OP : S_EQ;
                        end else begin
                            acc_step = 1'b1;
                            cnt_n    = cnt + CW'(1);
                        end
                    end else if (rx_data == ASC_MINUS && cmd_signed &&
                                 cnt == '0 && !neg) begin
                        neg_n = 1'b1;
                    end else begin
                        fault      = 1'b1;
                        fault_code = ERR_DIGIT;
                    end
                end
                S_OP: begin
                    unique case (1'b1)
                        (rx_data == ASC_PLUS):  op_d = OP_ADD;
                        (rx_data == ASC_MINUS): op_d = OP_SUB;
                        (rx_data == ASC_STAR):  op_d = OP_MUL;
                        (rx_data == ASC_SLASH): op_d = OP_DIV;
                        default: begin
                            fault      = 1'b1;
                            fault_code = ERR_OP;
                        end
                    endcase
                    if (!fault) begin
                        ld_op   = 1'b1;
                        state_n = S_B_DIG;
                    end
                end
                S_EQ: begin
                    if (rx_data == ASC_EQ) state_n = S_HOLD;
                    else begin
                        fault      = 1'b1;
                        fault_code = ERR_EQ;
                    end
                end
                S_HOLD: begin
                    // overrun: byte dropped, pending command untouched
                    err_d  = 1'b1;
                    code_d = ERR_OVR;
                end
                default: state_n = S_IDLE;
            endcase
        end

        if (fault) begin
            state_n = S_IDLE;
            err_d   = 1'b1;
            code_d  = fault_code;
            acc_clr = 1'b1;
            cnt_n   = '0;
            neg_n   = 1'b0;
        end

        if (state == S_HOLD && cmd_ready) state_n = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            neg        <= 1'b0;
            cmd_signed <= 1'b0;
            cmd_op     <= 2'b00;
            cmd_a      <= '0;
            cmd_b      <= '0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            neg      <= neg_n;
            err      <= err_d;
            err_code <= code_d;
            if (ld_fmt) cmd_signed <= fmt_d;
            if (ld_op)  cmd_op     <= op_d;
            if (ld_a)   cmd_a      <= acc_res;
            if (ld_b)   cmd_b      <= acc_res;
        end
    end

    assign cmd_valid = (state == S_HOLD);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_cal_cmd_parser.sv
// Self-checking bench for cal_cmd_parser: per-scenario tasks plus a
// scoreboard of expected commands and error codes drained by a monitor.
module tb_cal_cmd_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_signed;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        err;
    logic [2:0]  err_code;
    logic        busy;

    typedef struct packed {
        logic        s;
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } cmd_t;

    cmd_t       exp_cmd[$];
    logic [2:0] exp_err[$];
    cmd_t       mon_e;
    logic [2:0] mon_c;
    int         checks   = 0;
    int         failures = 0;

    cal_cmd_parser #(.DIGITS(4), .OPW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_signed (cmd_signed),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .err        (err),
        .err_code   (err_code),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    // scoreboard monitor, samples mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid && cmd_ready) begin
                checks++;
                if (exp_cmd.size() == 0) begin
                    failures++;
                    $display("FAIL cmd_unexpected: got %h_%h_%h_%h expected none",
                             cmd_signed, cmd_op, cmd_a, cmd_b);
                end else begin
                    mon_e = exp_cmd.pop_front();
                    if ({cmd_signed, cmd_op, cmd_a, cmd_b} !== mon_e) begin
                        failures++;
                        $display("FAIL cmd_fields: got %h_%h_%h_%h expected %h_%h_%h_%h",
                                 cmd_signed, cmd_op, cmd_a, cmd_b,
                                 mon_e.s, mon_e.op, mon_e.a, mon_e.b);
                    end
                end
            end
            if (err) begin
                checks++;
                if (exp_err.size() == 0) begin
                    failures++;
                    $display("FAIL err_unexpected: got code %0d expected no err", err_code);
                end else begin
                    mon_c = exp_err.pop_front();
                    if (err_code !== mon_c) begin
                        failures++;
                        $display("FAIL err_code: got %0d expected %0d", err_code, mon_c);
                    end
                end
            end
        end
    end

    // callers are always positioned #1 after a rising edge
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_cmd(input logic s, input logic [1:0] op,
                            input logic [15:0] a, input logic [15:0] b);
        cmd_t c;
        c.s  = s;
        c.op = op;
        c.a  = a;
        c.b  = b;
        exp_cmd.push_back(c);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_cmd.size() != 0 || exp_err.size() != 0) && n < 40) begin
            idle(1);
            n++;
        end
        checks++;
        if (exp_cmd.size() != 0 || exp_err.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got %0d cmds %0d errs pending expected 0 0",
                     name, exp_cmd.size(), exp_err.size());
            exp_cmd.delete();
            exp_err.delete();
        end
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        cmd_ready = 1'b1;
        idle(3);
        checks++;
        if ({cmd_valid, cmd_signed, cmd_op, cmd_a, cmd_b, err, err_code, busy} !== 40'h0) begin
            failures++;
            $display("FAIL reset_outputs: got v%b s%b op%h a%h b%h e%b c%0d busy%b expected all 0",
                     cmd_valid, cmd_signed, cmd_op, cmd_a, cmd_b, err, err_code, busy);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_signed_mul;
        push_cmd(1'b1, 2'b10, 16'd14, 16'd4);
        send_str("I S 0014*0004=");
        checks++;
        if (cmd_valid !== 1'b1) begin
            failures++;
            $display("FAIL mul_latency: got cmd_valid %b expected 1", cmd_valid);
        end
        idle(1);
        checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mul_release: got valid %b busy %b expected 0 0", cmd_valid, busy);
        end
        wait_drain("signed_mul");
    endtask

    task automatic test_signed_neg;
        push_cmd(1'b1, 2'b00, 16'hFF85, 16'd456);
        send_str("I S -0123+0456=");
        idle(2);
        exp_err.push_back(3'd3);
        send_str("I U -0123+0456=");
        idle(2);
        checks++;
        if (busy !== 1'b0 || err_code !== 3'd3) begin
            failures++;
            $display("FAIL u_minus_state: got busy %b code %0d expected 0 3", busy, err_code);
        end
        push_cmd(1'b1, 2'b11, 16'hFFF9, 16'hFFFE);
        send_str("I S -0007/-0002=");
        wait_drain("signed_neg");
    endtask

    task automatic test_hold_overrun;
        cmd_ready = 1'b0;
        push_cmd(1'b0, 2'b11, 16'd9999, 16'd3);
        send_str("I U 9999/0003=");
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                exp_err.push_back(3'd6);
                send_byte(8'h58);
            end else begin
                idle(1);
            end
            checks++;
            if ({cmd_valid, cmd_signed, cmd_op, cmd_a, cmd_b} !== {1'b1, 1'b0, 2'b11, 16'd9999, 16'd3}) begin
                failures++;
                $display("FAIL hold_stable: got v%b s%b op%h a%h b%h expected 1 0 3 270f 0003",
                         cmd_valid, cmd_signed, cmd_op, cmd_a, cmd_b);
            end
        end
        cmd_ready = 1'b1;
        idle(1);
        checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL hold_release: got valid %b busy %b expected 0 0", cmd_valid, busy);
        end
        wait_drain("hold_overrun");
    endtask

    task automatic test_bad_digit;
        exp_err.push_back(3'd3);
        send_str("I S 00x4*0004=");
        idle(1);
        push_cmd(1'b0, 2'b01, 16'd2, 16'd5);
        send_str("I U 0002-0005=");
        wait_drain("bad_digit");
        exp_err.push_back(3'd1);
        send_str("IX");
        exp_err.push_back(3'd2);
        send_str("I Q");
        exp_err.push_back(3'd4);
        send_str("I U 0001%");
        exp_err.push_back(3'd5);
        send_str("I U 0001+00022");
        wait_drain("grammar_errs");
    endtask

    task automatic test_idle_garbage;
        send_byte(8'h0D);
        send_byte(8'h0A);
        send_byte(8'h41);
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL idle_garbage: got busy %b err %b expected 0 0", busy, err);
        end
        push_cmd(1'b1, 2'b10, 16'd123, 16'd10);
        send_str("I S 0123*0010=");
        wait_drain("idle_garbage");
    endtask

    task automatic test_back_to_back;
        push_cmd(1'b0, 2'b00, 16'd1234, 16'd5678);
        push_cmd(1'b1, 2'b01, 16'd0, 16'd1);
        send_str("I U 1234+5678=");
        idle(1);
        send_str("I S 0000-0001=");
        wait_drain("back_to_back");
        // handshake and overrun byte on the same edge
        cmd_ready = 1'b0;
        push_cmd(1'b1, 2'b11, 16'd8, 16'd2);
        send_str("I S 0008/0002=");
        idle(1);
        cmd_ready = 1'b1;
        exp_err.push_back(3'd6);
        send_byte(8'h49);
        checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL simul_hs: got valid %b busy %b expected 0 0", cmd_valid, busy);
        end
        wait_drain("simul_hs");
    endtask

    task automatic test_reset_midframe;
        send_str("I S 07");
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checks++;
        if ({cmd_valid, cmd_signed, cmd_op, cmd_a, cmd_b, err, err_code, busy} !== 40'h0) begin
            failures++;
            $display("FAIL mid_reset: got v%b s%b op%h a%h b%h e%b c%0d busy%b expected all 0",
                     cmd_valid, cmd_signed, cmd_op, cmd_a, cmd_b, err, err_code, busy);
        end
        push_cmd(1'b0, 2'b00, 16'd42, 16'd1);
        send_str("I U 0042+0001=");
        wait_drain("reset_midframe");
    endtask

    initial begin
        test_reset;
        test_signed_mul;
        test_signed_neg;
        test_hold_overrun;
        test_bad_digit;
        test_idle_garbage;
        test_back_to_back;
        test_reset_midframe;
        idle(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
